// File: rtl/tick_scheduler_pkg.sv
// tick_scheduler_pkg: shared FSM encoding, clog2 helper and default clock constants
package tick_scheduler_pkg;
  typedef enum logic [1:0] {IDLE, SAFE, ACK} state_e;
  localparam int DEF_CLK_HZ = 100_000_000;
  localparam int DEF_BASE_HZ = 1000;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/tick_channel.sv
// tick_channel: one timebase channel counting base ticks into a tick pulse and square wave
module tick_channel
  import tick_scheduler_pkg::*;
#(
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             base_tick,
  input  logic             commit,
  input  logic             cfg_en,
  input  logic [PER_W-1:0] cfg_period,
  output logic             tick,
  output logic             sq
);
  logic             en_q, en_d;
  logic [PER_W-1:0] period_q, period_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic             active, wrap;
  always_comb begin
    active   = en_q && (period_q != '0);
    wrap     = cnt_q == period_q - PER_W'(1);
    en_d     = commit ? cfg_en : en_q;
    period_d = commit ? cfg_period : period_q;
    tick_d   = !commit && active && base_tick && wrap;
    // a commit or an idle channel restarts from a clean phase
    cnt_d    = (commit || !active) ? '0 : !base_tick ? cnt_q : wrap ? '0 : cnt_q + PER_W'(1);
    sq_d     = (commit || !active) ? 1'b0 : sq_q ^ tick_d;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q     <= 1'b0;
      period_q <= '0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      sq_q     <= 1'b0;
    end else begin
      en_q     <= en_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      sq_q     <= sq_d;
    end
  end
  assign tick = tick_q;
  assign sq   = sq_q;
endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: shared prescaler plus config FSM driving NUM_CH tick channels
module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter int CLK_HZ  = DEF_CLK_HZ,
  parameter int BASE_HZ = DEF_BASE_HZ,
  parameter int NUM_CH  = 4,
  parameter int PER_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic              cfg_en,
  input  logic [PER_W-1:0]  cfg_period,
  output logic              base_tick,
  output logic [NUM_CH-1:0] tick_out,
  output logic [NUM_CH-1:0] sq_out
);
  localparam int PRESC = CLK_HZ / BASE_HZ;
  localparam int PW    = clog2(PRESC);
  logic [PW-1:0]    presc_q, presc_d;
  logic             base_tick_q, base_tick_d;
  state_e           state_q, state_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic [2:0]       hold_ch_q, hold_ch_d;
  logic             hold_en_q, hold_en_d;
  logic [PER_W-1:0] hold_period_q, hold_period_d;
  logic             presc_wrap, commit;
  always_comb begin
    presc_wrap    = presc_q == PW'(PRESC - 1);
    presc_d       = presc_wrap ? '0 : presc_q + PW'(1);
    base_tick_d   = presc_wrap;
    state_d       = state_q;
    hold_ch_d     = hold_ch_q;
    hold_en_d     = hold_en_q;
    hold_period_d = hold_period_q;
    commit        = 1'b0;
    if (state_q == IDLE && cfg_valid) begin
      state_d       = SAFE;
      hold_ch_d     = cfg_ch;
      hold_en_d     = cfg_en;
      hold_period_d = cfg_period;
    end else if (state_q == SAFE && !base_tick_q) begin
      // never commit while channels are counting
      state_d = ACK;
      commit  = 1'b1;
    end else if (state_q == ACK) begin
      state_d = IDLE;
    end
    cfg_ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q       <= '0;
      base_tick_q   <= 1'b0;
      state_q       <= IDLE;
      cfg_ready_q   <= 1'b1;
      hold_ch_q     <= '0;
      hold_en_q     <= 1'b0;
      hold_period_q <= '0;
    end else begin
      presc_q       <= presc_d;
      base_tick_q   <= base_tick_d;
      state_q       <= state_d;
      cfg_ready_q   <= cfg_ready_d;
      hold_ch_q     <= hold_ch_d;
      hold_en_q     <= hold_en_d;
      hold_period_q <= hold_period_d;
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_channel #(.PER_W(PER_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .base_tick (base_tick_q),
      .commit    (commit && hold_ch_q == 3'(i)),
      .cfg_en    (hold_en_q),
      .cfg_period(hold_period_q),
      .tick      (tick_out[i]),
      .sq        (sq_out[i])
    );
  end
  assign base_tick = base_tick_q;
  assign cfg_ready = cfg_ready_q;
endmodule
